// File: rtl/ysyx_22040365_lsu_mem.sv
// Load/store unit memory stage: one outstanding access over a valid/ready
// request channel with a response timeout and load-result extension.
`timescale 1ns/1ps

package ysyx_22040365_pkg;
  localparam logic [7:0] INST_LB  = 8'h01;
  localparam logic [7:0] INST_LBU = 8'h02;
  localparam logic [7:0] INST_LH  = 8'h03;
  localparam logic [7:0] INST_LHU = 8'h04;
  localparam logic [7:0] INST_LW  = 8'h05;
  localparam logic [7:0] INST_LWU = 8'h06;
  localparam logic [7:0] INST_LD  = 8'h07;
  localparam logic [7:0] INST_SB  = 8'h08;
  localparam logic [7:0] INST_SH  = 8'h09;
  localparam logic [7:0] INST_SW  = 8'h0a;
  localparam logic [7:0] INST_SD  = 8'h0b;
endpackage

module ysyx_22040365_lsu_mem #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_67,
  input  logic        store_67,
  input  logic [7:0]  inst_opcode_67,
  input  logic [63:0] ex_data_67,
  input  logic [63:0] store_data_67,
  input  logic [63:0] wmask_67,
  input  logic        rd_en_67,
  input  logic [4:0]  rd_addr_67,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic        wb_rd_en,
  output logic [4:0]  wb_rd_addr,
  output logic [63:0] wb_data,
  output logic        lsu_err
);
  import ysyx_22040365_pkg::*;

  localparam int CB = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = (CB > 8) ? CB : 8;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [7:0]  op_q, op_d;
  logic        we_q, we_d;
  logic        rd_en_q, rd_en_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        err_q, err_d;
  logic [7:0]  strb;
  logic        unused_wmask;

  assign unused_wmask = ^wmask_67;

  always_comb begin
    strb = '0;
    for (int i = 0; i < 8; i++) strb[i] = wmask_67[8*i];
  end

  function automatic logic [63:0] extract(
    input logic [7:0]  op,
    input logic [2:0]  off,
    input logic [63:0] rd
  );
    logic [63:0] b, h, w;
    b = rd >> {off, 3'b000};
    h = rd >> {off[2:1], 4'b0000};
    w = rd >> {off[2], 5'b00000};
    case (op)
      INST_LB:  extract = {{56{b[7]}}, b[7:0]};
      INST_LBU: extract = {56'd0, b[7:0]};
      INST_LH:  extract = {{48{h[15]}}, h[15:0]};
      INST_LHU: extract = {48'd0, h[15:0]};
      INST_LW:  extract = {{32{w[31]}}, w[31:0]};
      INST_LWU: extract = {32'd0, w[31:0]};
      default:  extract = rd;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    op_d      = op_q;
    we_d      = we_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_67 | store_67) begin
          state_d   = S_REQ;
          addr_d    = ex_data_67;
          op_d      = inst_opcode_67;
          we_d      = ~load_67;
          wdata_d   = load_67 ? '0 : store_data_67;
          wstrb_d   = load_67 ? '0 : strb;
          rd_en_d   = rd_en_67;
          rd_addr_d = rd_addr_67;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response on the final counted cycle still wins over the timeout
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          res_d   = we_q ? '0 : extract(op_q, addr_q[2:0], mem_rsp_rdata);
        end else if (cnt_q == LIM) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          res_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      op_q      <= '0;
      we_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      op_q      <= op_d;
      we_q      <= we_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  logic in_req, in_done;
  assign in_req  = (state_q == S_REQ);
  assign in_done = (state_q == S_DONE);

  assign mem_req_valid = in_req;
  assign mem_req_we    = in_req & we_q;
  assign mem_req_addr  = in_req ? {addr_q[63:3], 3'b000} : '0;
  assign mem_req_wdata = in_req ? wdata_q : '0;
  assign mem_req_wstrb = in_req ? wstrb_q : '0;

  assign lsu_stall = (state_q == S_IDLE) ? (load_67 | store_67) :
                     (in_req | (state_q == S_WAIT));

  assign wb_valid   = in_done;
  assign wb_rd_en   = in_done & rd_en_q & ~we_q & ~err_q;
  assign wb_rd_addr = in_done ? rd_addr_q : '0;
  assign wb_data    = in_done ? res_q : '0;
  assign lsu_err    = in_done & err_q;

endmodule

// File: tb/tb_ysyx_22040365_lsu_mem.sv
// Randomized bench for ysyx_22040365_lsu_mem against a transaction-level
// timeline model, plus directed literal cases.
`timescale 1ns/1ps

module tb_ysyx_22040365_lsu_mem;
  import ysyx_22040365_pkg::*;

  localparam int TO = 4;

  logic        clk, rst;
  logic        load_67, store_67;
  logic [7:0]  inst_opcode_67;
  logic [63:0] ex_data_67, store_data_67, wmask_67;
  logic        rd_en_67;
  logic [4:0]  rd_addr_67;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        lsu_stall, wb_valid, wb_rd_en, lsu_err;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_data;

  ysyx_22040365_lsu_mem #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .load_67(load_67), .store_67(store_67),
    .inst_opcode_67(inst_opcode_67),
    .ex_data_67(ex_data_67), .store_data_67(store_data_67),
    .wmask_67(wmask_67), .rd_en_67(rd_en_67), .rd_addr_67(rd_addr_67),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .lsu_stall(lsu_stall), .wb_valid(wb_valid), .wb_rd_en(wb_rd_en),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .lsu_err(lsu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [7:0]  op;
    logic [63:0] addr, sdata, wmask, rdata;
    logic        rd_en;
    logic [4:0]  rd_addr;
    int          r, w;
  } txn_t;

  int total = 0;
  int bad = 0;

  logic        chk_en = 1'b0;
  logic        e_rv, e_we, e_stall, e_wbv, e_rden, e_err;
  logic [63:0] e_addr, e_wdata, e_data;
  logic [7:0]  e_strb;
  logic [4:0]  e_rda;

  int          stall_seen, wbv_seen;
  logic [63:0] o_addr, o_wdata, o_data;
  logic [7:0]  o_strb;
  logic        o_we, o_err, o_rden;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", lsu_stall, e_stall);
      chk("req_valid", mem_req_valid, e_rv);
      chk("req_we", mem_req_we, e_we);
      chk("req_addr", mem_req_addr, e_addr);
      chk("req_wdata", mem_req_wdata, e_wdata);
      chk("req_wstrb", mem_req_wstrb, e_strb);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_rd_en", wb_rd_en, e_rden);
      chk("wb_rd_addr", wb_rd_addr, e_rda);
      chk("wb_data", wb_data, e_data);
      chk("lsu_err", lsu_err, e_err);
      if (lsu_stall) stall_seen++;
      if (mem_req_valid) begin
        o_addr = mem_req_addr; o_wdata = mem_req_wdata;
        o_strb = mem_req_wstrb; o_we = mem_req_we;
      end
      if (wb_valid) begin
        wbv_seen++;
        o_data = wb_data; o_err = lsu_err; o_rden = wb_rd_en;
      end
    end
  end

  task automatic exp_zero();
    e_rv = 0; e_we = 0; e_stall = 0; e_wbv = 0; e_rden = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_data = '0; e_strb = '0; e_rda = '0;
  endtask

  function automatic logic [63:0] ref_load(input logic [7:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] d);
    int off, sz;
    bit sgn;
    logic [63:0] v, m;
    off = int'(a % 8);
    sz = 8; sgn = 0;
    if (op == INST_LB || op == INST_LBU) sz = 1;
    if (op == INST_LH || op == INST_LHU) sz = 2;
    if (op == INST_LW || op == INST_LWU) sz = 4;
    sgn = (op == INST_LB || op == INST_LH || op == INST_LW);
    off = (off / sz) * sz;
    v = d >> (8 * off);
    if (sz < 8) begin
      m = 64'd1 << (8 * sz);
      v = v % m;
      if (sgn && v >= m / 2) v = v - m;
    end
    return v;
  endfunction

  function automatic logic [7:0] strb_of(input logic [63:0] wm);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = ((wm >> (8 * i)) & 64'd1) != 0;
    return s;
  endfunction

  task automatic rand_bus();
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_rsp_rdata = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      load_67 = 0; store_67 = 0;
      inst_opcode_67 = 8'($urandom);
      ex_data_67 = {$urandom, $urandom};
      rand_bus();
      exp_zero();
    end
  endtask

  task automatic run_txn(input txn_t t, input int rst_w);
    int nw;
    @(posedge clk); #1;
    stall_seen = 0; wbv_seen = 0;
    load_67 = t.ld; store_67 = t.st; inst_opcode_67 = t.op;
    ex_data_67 = t.addr; store_data_67 = t.sdata; wmask_67 = t.wmask;
    rd_en_67 = t.rd_en; rd_addr_67 = t.rd_addr;
    rand_bus();
    exp_zero(); e_stall = 1;
    for (int k = 0; k <= t.r; k++) begin
      @(posedge clk); #1;
      rand_bus();
      mem_req_ready = (k == t.r);
      exp_zero(); e_stall = 1; e_rv = 1; e_we = ~t.ld;
      e_addr = t.addr - (t.addr % 8);
      e_wdata = t.ld ? 64'd0 : t.sdata;
      e_strb = t.ld ? 8'd0 : strb_of(t.wmask);
    end
    nw = (t.w < 0) ? TO : t.w + 1;
    for (int j = 0; j < nw; j++) begin
      @(posedge clk); #1;
      rand_bus();
      mem_rsp_valid = (j == t.w);
      if (j == t.w) mem_rsp_rdata = t.rdata;
      exp_zero(); e_stall = 1;
      if (j == rst_w) begin
        rst = 1; load_67 = 0; store_67 = 0; mem_rsp_valid = 0;
        exp_zero();
        @(posedge clk); #1;
        rst = 0; mem_rsp_valid = 1; mem_rsp_rdata = t.rdata;
        @(negedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    rand_bus();
    exp_zero(); e_wbv = 1; e_rda = t.rd_addr;
    if (t.w >= 0) begin
      e_data = t.ld ? ref_load(t.op, t.addr, t.rdata) : 64'd0;
      e_rden = t.ld & t.rd_en;
    end else begin
      e_err = 1;
    end
    @(negedge clk); #1;
  endtask

  function automatic txn_t mk(input logic ld, input logic st,
                              input logic [7:0] op, input logic [63:0] a,
                              input logic [63:0] sd, input logic [63:0] wm,
                              input logic [63:0] rd, input int r,
                              input int w);
    txn_t t;
    t.ld = ld; t.st = st; t.op = op; t.addr = a; t.sdata = sd;
    t.wmask = wm; t.rdata = rd; t.rd_en = 1; t.rd_addr = 5'd10;
    t.r = r; t.w = w;
    return t;
  endfunction

  initial begin
    logic [7:0] lops [7];
    logic [7:0] sops [4];
    int szs [4];
    txn_t t;
    lops = '{INST_LB, INST_LBU, INST_LH, INST_LHU, INST_LW, INST_LWU, INST_LD};
    sops = '{INST_SB, INST_SH, INST_SW, INST_SD};
    szs = '{1, 2, 4, 8};

    rst = 1; load_67 = 0; store_67 = 0; inst_opcode_67 = 0;
    ex_data_67 = 0; store_data_67 = 0; wmask_67 = 0;
    rd_en_67 = 0; rd_addr_67 = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    exp_zero();
    chk_en = 1;
    @(posedge clk); #1;
    load_67 = 1; exp_zero(); e_stall = 1;
    @(posedge clk); #1;
    load_67 = 0; rst = 0; exp_zero();
    idle(2);

    run_txn(mk(1, 0, INST_LB, 64'h80000003, 0, 0,
               64'h11223344_85667788, 0, 0), -1);
    chk("lb_addr", o_addr, 64'h80000000);
    chk("lb_data", o_data, 64'hFFFFFFFF_FFFFFF85);
    run_txn(mk(1, 0, INST_LBU, 64'h80000003, 0, 0,
               64'h11223344_85667788, 0, 0), -1);
    chk("lbu_data", o_data, 64'h85);
    run_txn(mk(0, 1, INST_SW, 64'h80000004, 64'hA5A5A5A5_00000000,
               64'hFFFFFFFF_00000000, 0, 0, 1), -1);
    chk("sw_we", o_we, 1);
    chk("sw_strb", o_strb, 8'hF0);
    chk("sw_wdata", o_wdata, 64'hA5A5A5A5_00000000);
    chk("sw_rden", o_rden, 0);
    chk("sw_data", o_data, 0);
    run_txn(mk(1, 0, INST_LHU, 64'h80000006, 0, 0,
               64'hBEEF0000_00000000, 1, 0), -1);
    chk("lhu_data", o_data, 64'hBEEF);
    run_txn(mk(1, 1, INST_LH, 64'h80000006, 0, 64'hFF, 
               64'hBEEF0000_00000000, 0, 2), -1);
    chk("lh_data", o_data, 64'hFFFFFFFF_FFFFBEEF);
    chk("lh_prio_we", o_we, 0);
    idle(1);
    run_txn(mk(1, 0, INST_LW, 64'h80000100, 0, 0,
               64'h00000000_87654321, 2, 1), -1);
    chk("lw_stall_cyc", stall_seen, 6);
    chk("lw_wb_pulses", wbv_seen, 1);
    chk("lw_data", o_data, 64'hFFFFFFFF_87654321);
    run_txn(mk(1, 0, INST_LD, 64'h80000008, 0, 0, 0, 0, -1), -1);
    chk("to_err", o_err, 1);
    chk("to_rden", o_rden, 0);
    chk("to_stall_cyc", stall_seen, 6);
    idle(2);
    run_txn(mk(1, 0, INST_LD, 64'h80000010, 0, 0, 0, 0, 3), 1);
    chk("rst_no_wb", wbv_seen, 0);
    idle(1);
    run_txn(mk(1, 0, INST_LD, 64'h80000010, 0, 0,
               64'hDEADBEEF_CAFEF00D, 1, 0), -1);
    chk("post_rst_wb", wbv_seen, 1);
    chk("post_rst_data", o_data, 64'hDEADBEEF_CAFEF00D);

    for (int n = 0; n < 200; n++) begin
      t.ld = 1'($urandom);
      t.st = t.ld ? 1'($urandom) : 1'b1;
      t.op = t.ld ? lops[$urandom_range(0, 6)] : sops[$urandom_range(0, 3)];
      t.addr = {$urandom, $urandom};
      t.sdata = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        t.wmask = {$urandom, $urandom};
      end else begin
        int sz, off;
        sz = szs[$urandom_range(0, 3)];
        off = (int'(t.addr % 8) / sz) * sz;
        t.wmask = 0;
        for (int b = 0; b < sz; b++)
          t.wmask = t.wmask | (64'hFF << (8 * (off + b)));
      end
      t.rdata = {$urandom, $urandom};
      t.rd_en = 1'($urandom);
      t.rd_addr = 5'($urandom);
      t.r = $urandom_range(0, 3);
      t.w = $urandom_range(0, 4);
      if (t.w == 4) t.w = -1;
      run_txn(t, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22040365_lsu_mem.md
YSYX_22040365_LSU_MEM -- requirements
Module: ysyx_22040365_lsu_mem

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of WAIT cycles before an access is aborted with an error.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-003 SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- load_67  in  1  load request from EX/MEM
- store_67  in  1  store request from EX/MEM
- inst_opcode_67  in  8  opcode code (INST_LB/LBU/LH/LHU/LW/LWU/LD/SB/SH/SW/SD from the shared defines file)
- ex_data_67  in  64  effective byte address
- store_data_67  in  64  store data, already lane-aligned
- wmask_67  in  64  bit-level store mask, already lane-aligned
- rd_en_67  in  1  destination write enable
- rd_addr_67  in  5  destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1=write, 0=read
- mem_req_addr  out  64  ex_data_67 with bits[2:0] forced to 0
- mem_req_wdata  out  64  write data
- mem_req_wstrb  out  8  byte strobes; bit i = wmask_67[8i]
- mem_rsp_valid  in  1  read data valid / write acknowledge
- mem_rsp_rdata  in  64  read doubleword
- lsu_stall  out  1  freeze upstream pipeline
- wb_valid  out  1  one-cycle completion pulse
- wb_rd_en  out  1  registered rd_en (0 for stores and errors)
- wb_rd_addr  out  5  registered rd_addr
- wb_data  out  64  extended load result
- lsu_err  out  1  timeout flag, valid with wb_valid

Function
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-005 IDLE: if load_67 or store_67, SHALL capture address, data, wstrb, opcode, rd_en, and rd_addr, then go to REQ; load_67 has priority when both are asserted (the access is treated as a read).
REQ-006 Non-memory instructions (load_67 = store_67 = 0) SHALL cause no state change and no stall.
REQ-007 lsu_stall SHALL equal (load_67|store_67) combinationally in IDLE, be 1 in REQ and WAIT, and be 0 in DONE.
REQ-008 REQ: mem_req_valid SHALL be 1, and the request fields SHALL be driven from the captured values, stable until mem_req_valid & mem_req_ready; the handshake moves to WAIT.
REQ-009 mem_req_wdata and mem_req_wstrb SHALL be 0 for reads.
REQ-010 WAIT: on mem_rsp_valid the FSM SHALL go to DONE and latch the result; mem_rsp_valid in IDLE, REQ, or DONE SHALL be ignored.
REQ-011 WAIT cycle counter SHALL be 8 bits or wider, cleared on entry to WAIT; at TIMEOUT_CYC cycles without a response the FSM SHALL go to DONE with lsu_err=1, wb_data=0, and wb_rd_en=0.
REQ-012 DONE SHALL last exactly one cycle with wb_valid=1, then return to IDLE; no new access is accepted in DONE.
REQ-013 Load extraction uses off = addr[2:0]:
- LB/LBU: byte[off]
- LH/LHU: halfword[off[2:1]], off[0] ignored
- LW/LWU: word[off[2]]
- LD: full 64 bits
- LB/LH/LW sign-extend to 64; LBU/LHU/LWU zero-extend.
REQ-014 Stores SHALL give wb_valid=1, wb_rd_en=0, wb_data=0.
REQ-015 Minimum load/store latency SHALL be 3 cycles (accept, REQ with ready=1, WAIT with rsp=1), then DONE.

Reset
REQ-016 rst SHALL immediately force IDLE, clear the counter, and drive 0 on all outputs (lsu_stall combinational per REQ-007).
REQ-017 Reset mid-operation SHALL abandon the access with no wb_valid; a late mem_rsp_valid after reset SHALL be ignored.

Verification
REQ-018 LB, addr 0x80000003, rdata 0x11223344_85667788 -> mem_req_addr 0x80000000, wb_data 0xFFFFFFFF_FFFFFF85; LBU -> 0x85.
REQ-019 SW, addr 0x80000004, wmask_67 0xFFFFFFFF_00000000 -> mem_req_we=1, mem_req_wstrb 0xF0, wdata = store_data_67, wb_rd_en=0.
REQ-020 LHU, addr off 6, rdata 0xBEEF0000_00000000 -> wb_data 0x000000000000BEEF; LH -> 0xFFFFFFFF_FFFFBEEF.
REQ-021 LW, ready delayed 3 cycles, rsp 2 cycles after handshake -> lsu_stall high 6 consecutive cycles, single wb_valid pulse.
REQ-022 LD, TIMEOUT_CYC=4, no rsp -> DONE after 4 WAIT cycles, lsu_err=1, wb_rd_en=0; then a late rsp is ignored.
REQ-023 rst pulse in WAIT -> IDLE within the same cycle, no wb_valid; the next load completes normally.
